// File: rtl/rvcpu_mem_pkg.sv
// rtl/rvcpu_mem_pkg.sv - load/store encodings, MEM-stage FSM states and access-size helper
package rvcpu_mem_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5,
    LD_LWU  = 3'd6,
    LD_LD   = 3'd7
  } ld_ctrl_e;

  typedef enum logic [2:0] {
    ST_NONE = 3'd0,
    ST_SB   = 3'd1,
    ST_SH   = 3'd2,
    ST_SW   = 3'd3,
    ST_SD   = 3'd4
  } st_ctrl_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } mem_state_e;

  // log2 of the access size in bytes for a store or load control field
  function automatic logic [1:0] size_of(input logic is_store, input logic [2:0] ctrl);
    logic [1:0] sz;
    sz = 2'd0;
    if (is_store) begin
      case (ctrl)
        ST_SH:   sz = 2'd1;
        ST_SW:   sz = 2'd2;
        ST_SD:   sz = 2'd3;
        default: sz = 2'd0;
      endcase
    end else begin
      case (ctrl)
        LD_LH, LD_LHU: sz = 2'd1;
        LD_LW, LD_LWU: sz = 2'd2;
        LD_LD:         sz = 2'd3;
        default:       sz = 2'd0;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane shift/strobe generation and load lane extract/extension
module mem_lane_align
  import rvcpu_mem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STRB_W = 8
) (
  input  logic [1:0]        size,
  input  logic [2:0]        offset,
  input  logic              ld_sext,
  input  logic [XLEN-1:0]   st_data,
  output logic [XLEN-1:0]   lane_wdata,
  output logic [STRB_W-1:0] lane_wstrb,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   ld_data
);

  logic [5:0]        bit_off;
  logic [STRB_W-1:0] base_strb;
  logic [XLEN-1:0]   shifted;

  assign bit_off    = {offset, 3'b000};
  assign lane_wdata = st_data << bit_off;
  assign lane_wstrb = base_strb << offset;
  assign shifted    = rdata >> bit_off;

  always_comb begin
    base_strb = STRB_W'(8'h01);
    ld_data   = shifted;
    case (size)
      2'd0: begin
        base_strb = STRB_W'(8'h01);
        ld_data   = {{(XLEN-8){ld_sext & shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        base_strb = STRB_W'(8'h03);
        ld_data   = {{(XLEN-16){ld_sext & shifted[15]}}, shifted[15:0]};
      end
      2'd2: begin
        base_strb = STRB_W'(8'h0F);
        ld_data   = {{(XLEN-32){ld_sext & shifted[31]}}, shifted[31:0]};
      end
      default: begin
        base_strb = STRB_W'(8'hFF);
        ld_data   = shifted;
      end
    endcase
  end

endmodule

// File: rtl/pipeline_mem_stage7.sv
// rtl/pipeline_mem_stage7.sv - MEM stage: req/ack data access, wait/hold FSM, MEM registers
// Optional PIPELINE_MEM_MISALIGN_EN: misaligned accesses skip memory and flag misalign_MEM.
module pipeline_mem_stage7
  import rvcpu_mem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STRB_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [XLEN-1:0]   pc_EXA,
  input  logic [XLEN-1:0]   alu_result_EXA,
  input  logic [XLEN-1:0]   reg_data2_EXA,
  input  logic [4:0]        rd_EXA,
  input  logic              rf_wr_en_EXA,
  input  logic [1:0]        rf_wr_sel_EXA,
  input  logic [2:0]        dm_rd_ctrl_EXA,
  input  logic [2:0]        dm_wr_ctrl_EXA,
  output logic              dm_req,
  output logic              dm_we,
  output logic [XLEN-1:0]   dm_addr,
  output logic [XLEN-1:0]   dm_wdata,
  output logic [STRB_W-1:0] dm_wstrb,
  input  logic              dm_ack,
  input  logic [XLEN-1:0]   dm_rdata,
  output logic              stall_req,
  output logic              misalign_MEM,
  output logic [XLEN-1:0]   pc_MEM,
  output logic [XLEN-1:0]   alu_result_MEM,
  output logic [4:0]        rd_MEM,
  output logic              rf_wr_en_MEM,
  output logic [1:0]        rf_wr_sel_MEM,
  output logic [XLEN-1:0]   dm_rdata_MEM
);

  mem_state_e        state, state_nxt;
  logic              st_op, ld_op, access, misal, req, ld_sext;
  logic              commit, take_hold;
  logic [1:0]        size;
  logic [2:0]        offset, lane_off, size_mask;
  logic [XLEN-1:0]   lane_wdata, ld_ext, hold_buf, commit_data;
  logic [STRB_W-1:0] lane_wstrb;

  // Store codes 5-7 are not stores; a valid store outranks a simultaneous load
  assign st_op   = dm_wr_ctrl_EXA inside {ST_SB, ST_SH, ST_SW, ST_SD};
  assign ld_op   = ~st_op & (dm_rd_ctrl_EXA != LD_NONE);
  assign access  = st_op | ld_op;
  assign ld_sext = dm_rd_ctrl_EXA inside {LD_LB, LD_LH, LD_LW, LD_LD};
  assign size    = size_of(st_op, st_op ? dm_wr_ctrl_EXA : dm_rd_ctrl_EXA);
  assign offset  = alu_result_EXA[2:0];

  always_comb begin
    case (size)
      2'd0:    size_mask = 3'b000;
      2'd1:    size_mask = 3'b001;
      2'd2:    size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
  end

`ifdef PIPELINE_MEM_MISALIGN_EN
  assign misal    = access & (|(offset & size_mask));
  assign lane_off = offset;
`else
  assign misal    = 1'b0;
  assign lane_off = offset & ~size_mask;
`endif

  assign req       = reset & access & ~misal & (state != S_HOLD);
  assign stall_req = req & ~dm_ack;
  assign dm_req    = req;
  assign dm_we     = req & st_op;
  assign dm_wstrb  = req ? lane_wstrb : '0;
  assign dm_addr   = {alu_result_EXA[XLEN-1:3], 3'b000};
  assign dm_wdata  = lane_wdata;

  mem_lane_align #(.XLEN(XLEN), .STRB_W(STRB_W)) u_align (
    .size       (size),
    .offset     (lane_off),
    .ld_sext    (ld_sext),
    .st_data    (reg_data2_EXA),
    .lane_wdata (lane_wdata),
    .lane_wstrb (lane_wstrb),
    .rdata      (dm_rdata),
    .ld_data    (ld_ext)
  );

  always_comb begin
    state_nxt   = state;
    commit      = 1'b0;
    take_hold   = 1'b0;
    commit_data = '0;
    case (state)
      S_IDLE, S_WAIT: begin
        commit_data = (ld_op & req) ? ld_ext : '0;
        if (req & dm_ack) begin
          if (stall) begin
            take_hold = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            commit    = 1'b1;
            state_nxt = S_IDLE;
          end
        end else if (req) begin
          state_nxt = S_WAIT;
        end else begin
          commit    = ~stall;
          state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        commit_data = hold_buf;
        if (~stall) begin
          commit    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      hold_buf       <= '0;
      pc_MEM         <= '0;
      alu_result_MEM <= '0;
      rd_MEM         <= '0;
      rf_wr_en_MEM   <= 1'b0;
      rf_wr_sel_MEM  <= '0;
      misalign_MEM   <= 1'b0;
      dm_rdata_MEM   <= '0;
    end else begin
      state <= state_nxt;
      if (take_hold) hold_buf <= commit_data;
      if (commit) begin
        pc_MEM         <= pc_EXA;
        alu_result_MEM <= alu_result_EXA;
        rd_MEM         <= rd_EXA;
        rf_wr_en_MEM   <= rf_wr_en_EXA & ~misal;
        rf_wr_sel_MEM  <= rf_wr_sel_EXA;
        misalign_MEM   <= misal;
        dm_rdata_MEM   <= commit_data;
      end
    end
  end

endmodule

// File: doc/pipeline_mem_stage7.md
# pipeline_mem_stage7

Memory-access stage of the 6-stage pipeline. Sits directly after the execution-ALU stage. It takes the EXA-stage register outputs (address, store data, access controls, writeback metadata) and performs the load or store over a single-outstanding req/ack data-memory port. It aligns and extends load data, holds the pipeline through memory wait states, and registers the results toward the writeback stage.

## Interface
Parameters:
- `XLEN`, 64: data/address width.
- `STRB_W`, 8: byte-strobe width (XLEN/8).

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `stall` in 1: global pipeline stall from the hazard unit. It already includes this block's `stall_req`.
- `pc_EXA` in 64: PC of the instruction in EXA.
- `alu_result_EXA` in 64: effective address, or ALU result for non-memory instructions.
- `reg_data2_EXA` in 64: store data.
- `rd_EXA` in 5: destination register.
- `rf_wr_en_EXA` in 1: register-file write enable.
- `rf_wr_sel_EXA` in 2: register-file write-data select.
- `dm_rd_ctrl_EXA` in 3: load type.
- `dm_wr_ctrl_EXA` in 3: store type.
- `dm_req` out 1: memory request.
- `dm_we` out 1: store when 1.
- `dm_addr` out 64: doubleword-aligned address (bits [2:0] = 0).
- `dm_wdata` out 64: store data shifted onto its byte lanes.
- `dm_wstrb` out 8: byte enables.
- `dm_ack` in 1: request completed this cycle.
- `dm_rdata` in 64: doubleword read data, valid with `dm_ack`.
- `stall_req` out 1: the stage needs the pipeline held.
- `misalign_MEM` out 1: registered misaligned-access flag.
- `pc_MEM`, `alu_result_MEM`, `rd_MEM`, `rf_wr_en_MEM`, `rf_wr_sel_MEM` out: registered pass-through to writeback.
- `dm_rdata_MEM` out 64: aligned, extended load result.

## Operation
- Load encoding (`dm_rd_ctrl`): 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 LD.
- Store encoding (`dm_wr_ctrl`): 0 none, 1 SB, 2 SH, 3 SW, 4 SD; values 5–7 are treated as none.
- An access is present when either control field is nonzero. If both are nonzero, the store takes priority.
- Lane select is `alu_result_EXA[2:0]`.
  - Loads: select the lanes of `dm_rdata`, then sign- or zero-extend to 64 bits.
  - Stores: replicate/shift `reg_data2_EXA` onto the addressed lanes. `dm_wstrb` has 1/2/4/8 contiguous bits starting at the lane offset.
- FSM states:
  - IDLE:
    - Access present → `dm_req`=1.
    - `dm_ack` and `~stall` → commit to the MEM registers, stay in IDLE.
    - `dm_ack` and `stall` → latch the extended data into the hold buffer, go to HOLD.
    - No ack → go to WAIT.
  - WAIT: `dm_req` held at 1 with stable address, data and strobe. On `dm_ack`, behave exactly as IDLE does on ack.
  - HOLD: `dm_req`=0, no reissue. On `~stall`, commit the buffered data and go to IDLE.
- `stall_req` = access present & state∈{IDLE,WAIT} & `~dm_ack`.
- Non-memory instructions: no request; registers update on `~stall`. `dm_rdata_MEM` is 0 for non-loads and for stores.
- On `stall` with no commit, all MEM registers hold their value.

## Timing
- Reset values: all `*_MEM` outputs 0, `misalign_MEM` 0, FSM in IDLE. `dm_req`, `dm_we`, `dm_wstrb` and `stall_req` are forced 0 while `reset` is low.
- `dm_req`, `dm_addr`, `dm_wdata`, `dm_wstrb` and `stall_req` are combinational from the EXA inputs and the FSM state.
- Zero-wait access (ack in the same cycle as req): result is visible in `*_MEM` after 1 edge and `stall_req` is never asserted.
- N-wait access: `stall_req` is high for N cycles; the commit happens on the edge of the ack cycle.
- Reset asserted mid-WAIT: the request is abandoned and the FSM returns to IDLE. An ack arriving after reset is ignored.
- Only one request is ever outstanding. A new request is never issued in the cycle after the ack of the same instruction.

## Configuration
- `PIPELINE_MEM_MISALIGN_EN` defined:
  - An access whose offset is not a multiple of its size issues no request and completes in 1 cycle.
  - `misalign_MEM`=1 and `rf_wr_en_MEM`=0 for that instruction.
- Undefined: the low address bits are cleared to size alignment, the access proceeds, and `misalign_MEM` is tied to 0.

## Structure
- Package `rvcpu_mem_pkg`: load/store encoding enums, FSM state enum, and the `size_of(ctrl)` function.
- Sub-module `mem_lane_align` (combinational): store lane shift and strobe generation, plus load lane extract and extension.
- Top level: FSM, hold buffer, MEM pipeline registers.

## Test plan
- LB at addr 0x1003 with rdata 0x00000000_80000000 and zero-wait ack → `dm_rdata_MEM`=0xFFFFFFFF_FFFFFF80 and `stall_req` never 1.
- SH at addr 0x2006 with data 0xABCD → `dm_wstrb`=0xC0, `dm_wdata[63:48]`=0xABCD, `dm_we`=1.
- LD with ack after 3 cycles → `stall_req` high for exactly 3 cycles, one request, correct data committed on the ack edge.
- Ack arrives while an external `stall`=1 for 2 cycles → HOLD state, no reissue, and data commits on the first `~stall` edge.
- Reset pulsed during WAIT → all outputs 0 and IDLE, with a late ack ignored.
- With `PIPELINE_MEM_MISALIGN_EN`, LW at 0x1002 → no `dm_req`, `misalign_MEM`=1, `rf_wr_en_MEM`=0.
